// File: rtl/uart_cmd_sequencer.sv
// Framed write-command parser behind a byte-handshake UART: SYNC, addr_hi, addr_lo, len, data...
// Optional trailing checksum byte when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 41000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_full,
   output logic        rx_ack,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        wr_strobe,
   input  logic        wr_busy,
   output logic        frame_ok,
   output logic        frame_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_DONE
`ifdef UART_CMD_CHECKSUM_EN
      , S_CHECK
`endif
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_ack, w_ack_nxt;
   logic [15:0] r_addr, w_addr_nxt;
   logic [7:0]  r_data, w_data_nxt;
   logic        r_strobe, w_strobe_nxt;
   logic        r_ok, w_ok_nxt;
   logic        r_err, w_err_nxt;
   logic [8:0]  r_count, w_count_nxt;
   logic [15:0] r_tmo, w_tmo_nxt;
   logic [1:0]  r_hold, w_hold_nxt;
   logic        w_cnt_st, w_wait, w_tmo_hit, w_accept;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]  r_sum, w_sum_nxt, w_sum_add;
   assign w_sum_add = r_sum + rx_data;
   assign w_cnt_st  = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                      (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHECK);
`else
   assign w_cnt_st  = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                      (r_state == S_LEN) || (r_state == S_DATA);
`endif

   assign w_wait    = (r_state == S_IDLE) || w_cnt_st;
   assign w_tmo_hit = w_cnt_st && (r_tmo == 16'(TIMEOUT_CYCLES - 1));
   // Timeout outranks a simultaneous rx_full: the byte stays pending and is parsed from IDLE.
   assign w_accept  = w_wait && rx_full && (r_hold == 2'd0) && !w_tmo_hit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ack    <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_strobe <= 1'b0;
         r_ok     <= 1'b0;
         r_err    <= 1'b0;
         r_count  <= '0;
         r_tmo    <= '0;
         r_hold   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         r_sum    <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ack    <= w_ack_nxt;
         r_addr   <= w_addr_nxt;
         r_data   <= w_data_nxt;
         r_strobe <= w_strobe_nxt;
         r_ok     <= w_ok_nxt;
         r_err    <= w_err_nxt;
         r_count  <= w_count_nxt;
         r_tmo    <= w_tmo_nxt;
         r_hold   <= w_hold_nxt;
`ifdef UART_CMD_CHECKSUM_EN
         r_sum    <= w_sum_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ack_nxt    = w_accept;
      w_addr_nxt   = r_addr;
      w_data_nxt   = r_data;
      w_strobe_nxt = 1'b0;
      w_ok_nxt     = 1'b0;
      w_err_nxt    = 1'b0;
      w_count_nxt  = r_count;
      w_hold_nxt   = w_accept ? 2'd2 : ((r_hold != 2'd0) ? r_hold - 2'd1 : 2'd0);
`ifdef UART_CMD_CHECKSUM_EN
      w_sum_nxt    = w_accept ? w_sum_add : r_sum;
`endif
      if (w_tmo_hit) begin
         w_err_nxt   = 1'b1;
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept && rx_data == SYNC_BYTE) begin
               w_state_nxt = S_ADDR_HI;
`ifdef UART_CMD_CHECKSUM_EN
               w_sum_nxt   = '0;
`endif
            end
            S_ADDR_HI: if (w_accept) begin
               w_addr_nxt[15:8] = rx_data;
               w_state_nxt      = S_ADDR_LO;
            end
            S_ADDR_LO: if (w_accept) begin
               w_addr_nxt[7:0] = rx_data;
               w_state_nxt     = S_LEN;
            end
            S_LEN: if (w_accept) begin
               w_count_nxt = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
               w_state_nxt = S_DATA;
            end
            S_DATA: if (w_accept) begin
               w_data_nxt  = rx_data;
               w_state_nxt = S_WRITE;
            end
            // Strobe cycle and post-strobe bookkeeping both live in WRITE: address advances after the strobe.
            S_WRITE: if (r_strobe) begin
               w_addr_nxt  = r_addr + 16'd1;
               w_count_nxt = r_count - 9'd1;
`ifdef UART_CMD_CHECKSUM_EN
               w_state_nxt = (r_count == 9'd1) ? S_CHECK : S_DATA;
`else
               w_state_nxt = (r_count == 9'd1) ? S_DONE : S_DATA;
`endif
            end else if (!wr_busy) begin
               w_strobe_nxt = 1'b1;
            end
            S_DONE: begin
               w_ok_nxt    = 1'b1;
               w_state_nxt = S_IDLE;
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CHECK: if (w_accept) begin
               if (w_sum_add == 8'h00) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
`endif
            default: w_state_nxt = S_IDLE;
         endcase
      end
      w_tmo_nxt = (w_cnt_st && w_state_nxt == r_state) ? r_tmo + 16'd1 : '0;
   end

   assign rx_ack    = r_ack;
   assign wr_addr   = r_addr;
   assign wr_data   = r_data;
   assign wr_strobe = r_strobe;
   assign frame_ok  = r_ok;
   assign frame_err = r_err;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: UART handshake model, strobe scoreboard, frame vectors.
module tb_uart_cmd_sequencer;

   localparam int unsigned TMO = 300;
`ifdef UART_CMD_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_full;
   logic        rx_ack;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_strobe;
   logic        wr_busy;
   logic        frame_ok;
   logic        frame_err;

   always #5 clock = ~clock;

   uart_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_full(rx_full), .rx_ack(rx_ack),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe), .wr_busy(wr_busy),
      .frame_ok(frame_ok), .frame_err(frame_err)
   );

   typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [15:0] addr; logic [7:0] data; logic [15:0] exp_addr; logic [7:0] exp_data; } vec_t;

   wr_t        sb[$];
   vec_t       tbl[6];
   logic [7:0] dq[$];
   int checks = 0, errors = 0;
   int n_ack = 0, n_strobe = 0, n_ok = 0, n_err = 0, cyc = 0;
   int last_ack_cyc = 0, last_err_cyc = 0, f_ok0 = 0, f_err0 = 0;
   logic prev_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clock);
         cyc++;
         if (rx_ack) begin
            n_ack++;
            last_ack_cyc = cyc;
            check("ack_one_cycle", 32'(prev_ack), 32'd0);
         end
         if (wr_strobe) begin
            n_strobe++;
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("strobe_addr", 32'(wr_addr), 32'(e.addr));
               check("strobe_data", 32'(wr_data), 32'(e.data));
            end
         end
         if (frame_ok) begin
            n_ok++;
            check("ok_after_last_strobe", 32'(sb.size()), 32'd0);
         end
         if (frame_err) begin
            n_err++;
            last_err_cyc = cyc;
         end
         prev_ack = rx_ack;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(posedge clock); #1;
      rx_data = b;
      rx_full = 1'b1;
      while (!rx_ack && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      check("ack_seen", 32'(rx_ack), 32'd1);
      @(posedge clock); #1;
      rx_full = 1'b0;
   endtask

   task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [15:0] addr, input logic [7:0] d[$], input bit push_model);
      logic [7:0] sum, len8;
      len8 = 8'(d.size());
      sum  = addr[15:8] + addr[7:0] + len8;
      send_byte(8'hA5);
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      send_byte(len8);
      foreach (d[i]) begin
         if (push_model) push_exp(addr + 16'(i), d[i]);
         sum = sum + d[i];
         send_byte(d[i]);
      end
      if (CK != 0) send_byte(8'h00 - sum);
   endtask

   task automatic frame_start();
      f_ok0  = n_ok;
      f_err0 = n_err;
   endtask

   task automatic wait_frame(input string name, input int exp_ok);
      int n = 0;
      while (n_ok == f_ok0 && n_err == f_err0 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      check(name, 32'(n_ok - f_ok0), 32'(exp_ok));
      check("frame_err_count", 32'(n_err - f_err0), 32'(1 - exp_ok));
   endtask

   initial begin
      int a0, s0;
      tbl[0] = '{16'h0000, 8'h00, 16'h0000, 8'h00};
      tbl[1] = '{16'hFFFF, 8'hFF, 16'hFFFF, 8'hFF};
      tbl[2] = '{16'h8001, 8'hA5, 16'h8001, 8'hA5};
      tbl[3] = '{16'h00FF, 8'h5A, 16'h00FF, 8'h5A};
      tbl[4] = '{16'h7FFF, 8'h01, 16'h7FFF, 8'h01};
      tbl[5] = '{16'hABCD, 8'h80, 16'hABCD, 8'h80};

      reset = 1'b1; rx_data = '0; rx_full = 1'b0; wr_busy = 1'b0;
      fork monitor(); join_none
      repeat (3) @(negedge clock);
      check("rst_rx_ack", 32'(rx_ack), 32'd0);
      check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check("rst_frame_ok", 32'(frame_ok), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      @(posedge clock); #1 reset = 1'b0;

      // Two-byte frame with ack counting
      a0 = n_ack; s0 = n_strobe;
      frame_start();
      dq.delete(); dq.push_back(8'hAA); dq.push_back(8'hBB);
      push_exp(16'h1234, 8'hAA); push_exp(16'h1235, 8'hBB);
      send_frame(16'h1234, dq, 1'b0);
      wait_frame("basic_frame_ok", 1);
      check("basic_ack_count", 32'(n_ack - a0), 32'(6 + CK));
      check("basic_strobe_count", 32'(n_strobe - s0), 32'd2);

      // Junk in IDLE is acked and discarded
      a0 = n_ack; s0 = n_strobe;
      send_byte(8'h00);
      send_byte(8'hFF);
      repeat (5) @(negedge clock);
      check("junk_ack_count", 32'(n_ack - a0), 32'd2);
      check("junk_no_strobe", 32'(n_strobe - s0), 32'd0);
      frame_start();
      dq.delete(); dq.push_back(8'h5C);
      send_frame(16'h0010, dq, 1'b1);
      wait_frame("after_junk_ok", 1);

      // Address wrap
      frame_start();
      dq.delete(); dq.push_back(8'h01); dq.push_back(8'h02);
      push_exp(16'hFFFF, 8'h01); push_exp(16'h0000, 8'h02);
      send_frame(16'hFFFF, dq, 1'b0);
      wait_frame("wrap_ok", 1);

      // len = 0 means 256 bytes
      s0 = n_strobe;
      frame_start();
      dq.delete();
      for (int i = 0; i < 256; i++) dq.push_back(8'(i) ^ 8'h3C);
      send_frame(16'h0000, dq, 1'b1);
      wait_frame("len256_ok", 1);
      check("len256_strobes", 32'(n_strobe - s0), 32'd256);

      for (int unsigned i = 0; i < 6; i++) begin
         frame_start();
         dq.delete(); dq.push_back(tbl[i].data);
         push_exp(tbl[i].exp_addr, tbl[i].exp_data);
         send_frame(tbl[i].addr, dq, 1'b0);
         wait_frame("table_ok", 1);
      end

      // Truncated frame times out from LEN
      frame_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20);
      repeat (TMO + 10) @(negedge clock);
      check("tmo_err_count", 32'(n_err - f_err0), 32'd1);
      check("tmo_no_ok", 32'(n_ok - f_ok0), 32'd0);
      check("tmo_latency", 32'(last_err_cyc - last_ack_cyc), 32'(TMO));
      frame_start();
      dq.delete(); dq.push_back(8'h99);
      send_frame(16'h0300, dq, 1'b1);
      wait_frame("post_tmo_ok", 1);

      // wr_busy stall in WRITE longer than the timeout
      frame_start();
      @(posedge clock); #1 wr_busy = 1'b1;
      push_exp(16'h0040, 8'h77);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h40); send_byte(8'h01); send_byte(8'h77);
      s0 = n_strobe;
      repeat (500) @(negedge clock);
      check("busy_no_strobe", 32'(n_strobe - s0), 32'd0);
      check("busy_no_timeout", 32'(n_err - f_err0), 32'd0);
      @(posedge clock); #1 wr_busy = 1'b0;
      @(negedge clock);
      check("busy_fall_cycle_strobe", 32'(wr_strobe), 32'd0);
      @(negedge clock);
      check("busy_next_cycle_strobe", 32'(wr_strobe), 32'd1);
      if (CK != 0) send_byte(8'h48);
      wait_frame("busy_frame_ok", 1);

      // Asynchronous reset mid-frame
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      @(negedge clock);
      check("pre_reset_addr", 32'(wr_addr), 32'h1234);
      #2 reset = 1'b1;
      #1 check("mid_reset_outputs", 32'({rx_ack, wr_strobe, frame_ok, frame_err, wr_data, wr_addr}), 32'd0);
      @(posedge clock); #1 reset = 1'b0;
      frame_start();
      dq.delete(); dq.push_back(8'h42);
      send_frame(16'h0777, dq, 1'b1);
      wait_frame("post_reset_ok", 1);

`ifdef UART_CMD_CHECKSUM_EN
      frame_start();
      push_exp(16'h0000, 8'h10);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h10); send_byte(8'hEF);
      wait_frame("cksum_good_ok", 1);
      frame_start();
      push_exp(16'h0000, 8'h10);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h10); send_byte(8'hEE);
      wait_frame("cksum_bad_ok", 0);
`endif

      repeat (5) @(negedge clock);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
